// File: rtl/onewire_pkg.sv
// Shared types and constants for the 1-Wire bus scheduler.
package onewire_pkg;

  // Engine command codes.
  typedef enum logic [1:0] {
    CMD_WRITE    = 2'b00,
    CMD_READ     = 2'b01,
    CMD_RESET    = 2'b10,
    CMD_PRESENCE = 2'b11
  } cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // Requester index width; covers up to four requesters.
  localparam int IDX_W = 2;

  // Status word bit positions.
  localparam int STAT_BUSY  = 0;
  localparam int STAT_LOCK  = 1;
  localparam int STAT_PRES  = 2;
  localparam int STAT_TMO   = 3;
  localparam int STAT_OWNER = 4;

endpackage

// File: rtl/onewire_rr_arb.sv
// Round-robin arbiter with lock override. Grant is combinational and one-hot.
module onewire_rr_arb
  import onewire_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  input  logic             lock,
  input  logic [IDX_W-1:0] owner,
  output logic [NREQ-1:0]  grant
);

  int rank;
  int best;

  // Rank each requester by distance from last+1; lowest ranked requester wins.
  always_comb begin
    grant = '0;
    best  = NREQ;
    rank  = 0;
    for (int i = 0; i < NREQ; i++) begin
      rank = (i + NREQ - 1 - int'(last)) % NREQ;
      if (lock) begin
        if (req[i] && (IDX_W'(i) == owner)) best = i;
      end else if (req[i] && (best == NREQ || rank < ((best + NREQ - 1 - int'(last)) % NREQ))) begin
        best = i;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = (best == i);
    end
  end

endmodule

// File: rtl/onewire_bus_scheduler.sv
// Shares one 1-Wire transaction engine between up to four requesters.
//
//   state    | meaning
//   ---------+--------------------------------------------------
//   ST_IDLE  | arbitrate; accept one command from the winner
//   ST_ISSUE | pulse eng_start, clear the wait timer
//   ST_WAIT  | wait for eng_done or abort on timeout
//   ST_RESP  | pulse rsp_valid to the owner, update the lock
module onewire_bus_scheduler
  import onewire_pkg::*;
#(
  parameter int NREQ        = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     req_valid,
  input  logic [2*NREQ-1:0]   req_cmd,
  input  logic [8*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]     req_lock,
  output logic [NREQ-1:0]     req_ready,
  output logic [NREQ-1:0]     rsp_valid,
  output logic [7:0]          rsp_data,
  output logic                rsp_err,
  output logic                eng_start,
  output logic [1:0]          eng_cmd,
  output logic [7:0]          eng_data_in,
  output logic                eng_abort,
  input  logic                eng_done,
  input  logic [7:0]          eng_data_out,
  input  logic                eng_presence,
  output logic [7:0]          status
);

  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  state_t           state, state_nxt;
  logic [NREQ-1:0]  grant;
  logic [IDX_W-1:0] g_win, g_q, last_q, owner_q;
  logic [1:0]       cmd_sel;
  logic [7:0]       data_sel;
  logic             lock_sel, lock_q, lock_act;
  cmd_t             cmd_q;
  logic [7:0]       data_q;
  logic [TW-1:0]    timer;
  logic [7:0]       rsp_data_q;
  logic             rsp_err_q, pres_q, tmo_q;
  logic             timeout_hit;
  logic [7:0]       status_q, status_nxt;

  onewire_rr_arb #(.NREQ(NREQ)) u_arb (
    .req   (req_valid),
    .last  (last_q),
    .lock  (lock_act),
    .owner (owner_q),
    .grant (grant)
  );

  assign timeout_hit = (timer == TW'(TIMEOUT_CYC - 1));
  assign eng_cmd     = cmd_q;
  assign eng_data_in = data_q;
  assign rsp_data    = rsp_data_q;
  assign rsp_err     = rsp_err_q;
  assign status      = status_q;

  // Select the winning requester's index and command fields.
  always_comb begin
    g_win    = '0;
    cmd_sel  = '0;
    data_sel = '0;
    lock_sel = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        g_win    = IDX_W'(i);
        cmd_sel  = req_cmd[2*i +: 2];
        data_sel = req_data[8*i +: 8];
        lock_sel = req_lock[i];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic and strobe outputs; done beats a coincident timeout.
  always_comb begin
    state_nxt = state;
    req_ready = '0;
    rsp_valid = '0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    case (state)
      ST_IDLE: begin
        req_ready = grant;
        if (|grant) state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        eng_start = 1'b1;
        state_nxt = ST_WAIT;
      end
      ST_WAIT: begin
        if (eng_done) begin
          state_nxt = ST_RESP;
        end else if (timeout_hit) begin
          eng_abort = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        for (int i = 0; i < NREQ; i++) rsp_valid[i] = (g_q == IDX_W'(i));
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: command latch, wait timer, result capture, lock bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      g_q        <= '0;
      last_q     <= IDX_W'(NREQ - 1);
      owner_q    <= '0;
      lock_q     <= 1'b0;
      lock_act   <= 1'b0;
      cmd_q      <= CMD_WRITE;
      data_q     <= '0;
      timer      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      pres_q     <= 1'b0;
      tmo_q      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            g_q    <= g_win;
            last_q <= g_win;
            cmd_q  <= cmd_t'(cmd_sel);
            data_q <= data_sel;
            lock_q <= lock_sel;
          end
        end
        ST_ISSUE: timer <= '0;
        ST_WAIT: begin
          if (eng_done) begin
            rsp_data_q <= eng_data_out;
            pres_q     <= eng_presence;
            tmo_q      <= 1'b0;
            rsp_err_q  <= 1'b0;
          end else if (timeout_hit) begin
            tmo_q     <= 1'b1;
            rsp_err_q <= 1'b1;
          end
          if (timer != TW'(TIMEOUT_CYC)) timer <= timer + TW'(1);
        end
        ST_RESP: begin
          lock_act <= lock_q;
          if (lock_q) owner_q <= g_q;
        end
        default: ;
      endcase
    end
  end

  // Status word is a registered snapshot, one cycle behind the flags.
  always_comb begin
    status_nxt                         = '0;
    status_nxt[STAT_BUSY]              = (state != ST_IDLE);
    status_nxt[STAT_LOCK]              = lock_act;
    status_nxt[STAT_PRES]              = pres_q;
    status_nxt[STAT_TMO]               = tmo_q;
    status_nxt[STAT_OWNER +: IDX_W]    = owner_q;
  end

  // Status register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) status_q <= '0;
    else      status_q <= status_nxt;
  end

endmodule

// File: tb/tb_onewire_bus_scheduler.sv
// Bench for onewire_bus_scheduler: directed scenarios plus a randomized run
// against a transaction-level model of arbitration, lock and result flags.
module tb_onewire_bus_scheduler;

  localparam int N  = 2;
  localparam int TO = 16;

  logic         clk;
  logic         rst;
  logic [N-1:0] req_valid;
  logic [2*N-1:0] req_cmd;
  logic [8*N-1:0] req_data;
  logic [N-1:0] req_lock;
  logic [N-1:0] req_ready;
  logic [N-1:0] rsp_valid;
  logic [7:0]   rsp_data;
  logic         rsp_err;
  logic         eng_start;
  logic [1:0]   eng_cmd;
  logic [7:0]   eng_data_in;
  logic         eng_abort;
  logic         eng_done;
  logic [7:0]   eng_data_out;
  logic         eng_presence;
  logic [7:0]   status;

  int checks = 0;
  int errors = 0;

  // Transaction-level model state.
  int         m_last;
  bit         m_locked;
  int         m_owner;
  bit         m_pres;
  bit         m_sticky;
  logic [7:0] m_rsp_data;
  bit         m_err;

  onewire_bus_scheduler #(.NREQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_cmd      (req_cmd),
    .req_data     (req_data),
    .req_lock     (req_lock),
    .req_ready    (req_ready),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .eng_start    (eng_start),
    .eng_cmd      (eng_cmd),
    .eng_data_in  (eng_data_in),
    .eng_abort    (eng_abort),
    .eng_done     (eng_done),
    .eng_data_out (eng_data_out),
    .eng_presence (eng_presence),
    .status       (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_last     = N - 1;
    m_locked   = 0;
    m_owner    = 0;
    m_pres     = 0;
    m_sticky   = 0;
    m_rsp_data = 8'h00;
    m_err      = 0;
  endtask

  function automatic int exp_winner(input logic [N-1:0] v);
    if (m_locked) return v[m_owner] ? m_owner : -1;
    for (int k = 1; k <= N; k++) begin
      if (v[(m_last + k) % N]) return (m_last + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [7:0] exp_status();
    logic [7:0] s;
    s = 8'h00;
    s[1]   = m_locked;
    s[2]   = m_pres;
    s[3]   = m_sticky;
    s[5:4] = 2'(m_owner);
    return s;
  endfunction

  // One complete command from handshake to response; dly=0 means the engine never answers.
  task automatic run_cmd(input logic [N-1:0] v, input logic [2*N-1:0] cmds,
                         input logic [8*N-1:0] datas, input logic [N-1:0] locks,
                         input int dly, input logic [7:0] rd, input logic pr,
                         output int won);
    int w;
    logic [N-1:0] oh;
    req_valid = v;
    req_cmd   = cmds;
    req_data  = datas;
    req_lock  = locks;
    #1;
    w   = exp_winner(v);
    won = w;
    oh  = (w < 0) ? '0 : (N'(1) << w);
    checks++;
    if (req_ready !== oh) begin
      errors++;
      $display("FAIL ready: got %b want %b", req_ready, oh);
    end
    if (w < 0) return;
    tick();
    checks++;
    if (eng_start !== 1'b1 || eng_cmd !== cmds[2*w +: 2] || eng_data_in !== datas[8*w +: 8] || req_ready !== '0) begin
      errors++;
      $display("FAIL issue: start %b cmd %b data %h ready %b want start 1 cmd %b data %h ready 0",
               eng_start, eng_cmd, eng_data_in, req_ready, cmds[2*w +: 2], datas[8*w +: 8]);
    end
    if (dly > 0) begin
      for (int k = 1; k <= dly; k++) begin
        tick();
        if (k == dly) begin
          eng_done     = 1'b1;
          eng_data_out = rd;
          eng_presence = pr;
        end
        #1;
        if (k == 1) begin
          checks++;
          if (status[0] !== 1'b1) begin
            errors++;
            $display("FAIL busy: got %b want 1", status[0]);
          end
        end
        checks++;
        if (eng_abort !== 1'b0 || eng_start !== 1'b0 || rsp_valid !== '0) begin
          errors++;
          $display("FAIL wait: abort %b start %b rsp_valid %b want all 0", eng_abort, eng_start, rsp_valid);
        end
      end
      tick();
      eng_done = 1'b0;
      #1;
      m_pres = pr; m_sticky = 0; m_rsp_data = rd; m_err = 0;
      checks++;
      if (rsp_valid !== (N'(1) << w) || rsp_err !== 1'b0 || rsp_data !== rd || req_ready !== '0) begin
        errors++;
        $display("FAIL resp: rsp_valid %b err %b data %h want %b 0 %h", rsp_valid, rsp_err, rsp_data,
                 N'(1) << w, rd);
      end
    end else begin
      for (int k = 1; k <= TO; k++) begin
        tick();
        checks++;
        if (eng_abort !== (k == TO)) begin
          errors++;
          $display("FAIL abort_time: cycle %0d after start abort %b want %b", k, eng_abort, (k == TO));
        end
      end
      tick();
      m_sticky = 1; m_err = 1;
      checks++;
      if (rsp_valid !== (N'(1) << w) || rsp_err !== 1'b1) begin
        errors++;
        $display("FAIL timeout_resp: rsp_valid %b err %b want %b 1", rsp_valid, rsp_err, N'(1) << w);
      end
    end
    m_last = w;
    if (locks[w]) begin
      m_locked = 1;
      m_owner  = w;
    end else begin
      m_locked = 0;
    end
    tick();
  endtask

  task automatic check_status(input string tag);
    req_valid = '0;
    tick();
    checks++;
    if (status !== exp_status() || rsp_data !== m_rsp_data || rsp_err !== m_err) begin
      errors++;
      $display("FAIL status_%s: status %h data %h err %b want %h %h %b", tag, status, rsp_data, rsp_err,
               exp_status(), m_rsp_data, m_err);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = '0; req_cmd = '0; req_data = '0; req_lock = '0;
    eng_done = 1'b0; eng_data_out = 8'h00; eng_presence = 1'b0;
    model_reset();
    #2;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_cmd, eng_data_in, eng_abort, status} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: some output nonzero status %h ready %b", status, req_ready);
    end
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (status !== 8'h00 || req_ready !== '0) begin
      errors++;
      $display("FAIL reset_idle: status %h ready %b want 00 0", status, req_ready);
    end
  endtask

  task automatic test_fairness();
    int won;
    int order [4] = '{0, 1, 0, 1};
    for (int i = 0; i < 4; i++) begin
      run_cmd(2'b11, 4'($urandom), 16'($urandom), 2'b00, 1 + i, 8'($urandom), 1'b0, won);
      checks++;
      if (won !== order[i]) begin
        errors++;
        $display("FAIL fair_order: grant %0d got %0d want %0d", i, won, order[i]);
      end
    end
    check_status("fair");
  endtask

  task automatic test_single();
    int won;
    run_cmd(2'b01, 4'b0000, 16'h00A5, 2'b00, 3, 8'h00, 1'b0, won);
    check_status("single");
  endtask

  task automatic test_lock();
    int won;
    run_cmd(2'b11, 4'b1000, 16'h1122, 2'b10, 2, 8'h00, 1'b1, won);
    checks++;
    if (won !== 1) begin
      errors++;
      $display("FAIL lock_take: got %0d want 1", won);
    end
    check_status("locked");
    req_valid = 2'b01;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (req_ready !== 2'b00 || eng_start !== 1'b0) begin
        errors++;
        $display("FAIL lock_block: ready %b start %b want 00 0", req_ready, eng_start);
      end
      tick();
    end
    for (int k = 0; k < 2; k++) begin
      run_cmd(2'b11, 4'b0100, 16'h3344, 2'b10, 2, 8'h55, 1'b1, won);
      checks++;
      if (won !== 1) begin
        errors++;
        $display("FAIL lock_hold: cmd %0d got %0d want 1", k, won);
      end
    end
    run_cmd(2'b11, 4'b0000, 16'h6677, 2'b00, 1, 8'h99, 1'b1, won);
    check_status("released");
    run_cmd(2'b11, 4'b0000, 16'h8899, 2'b00, 1, 8'h00, 1'b1, won);
    checks++;
    if (won !== 0) begin
      errors++;
      $display("FAIL lock_release: got %0d want 0", won);
    end
    check_status("after_release");
  endtask

  task automatic test_timeout();
    int won;
    run_cmd(2'b01, 4'b0001, 16'h0000, 2'b00, 0, 8'h00, 1'b0, won);
    check_status("timeout");
    run_cmd(2'b10, 4'b0000, 16'h0000, 2'b00, 2, 8'h12, 1'b0, won);
    check_status("timeout_clear");
  endtask

  task automatic test_read();
    int won;
    run_cmd(2'b10, 4'b0100, 16'h0000, 2'b00, 4, 8'h3C, 1'b1, won);
    check_status("read");
  endtask

  task automatic test_done_ignored();
    eng_done = 1'b1; eng_data_out = 8'hFF; eng_presence = ~m_pres;
    tick();
    eng_done = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== '0 || status[0] !== 1'b0) begin
      errors++;
      $display("FAIL stray_done: rsp_valid %b busy %b want 0 0", rsp_valid, status[0]);
    end
    check_status("stray_done");
  endtask

  task automatic test_random();
    int won;
    logic [N-1:0] v;
    logic [N-1:0] lk;
    int dly;
    for (int i = 0; i < 40; i++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      if (m_locked) v[m_owner] = 1'b1;
      lk = '0;
      for (int j = 0; j < N; j++) lk[j] = ($urandom_range(0, 3) == 0);
      dly = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 8);
      run_cmd(v, (2*N)'($urandom), (8*N)'($urandom), lk, dly, 8'($urandom), 1'($urandom), won);
      if ($urandom_range(0, 1) == 1) check_status("random");
    end
    check_status("random_end");
  endtask

  task automatic test_reset_mid();
    int won;
    req_valid = 2'b11; req_cmd = 4'b0101; req_data = 16'hABCD; req_lock = 2'b00;
    tick();
    req_valid = '0;
    tick();
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, eng_start, eng_cmd, eng_data_in, eng_abort, status} !== '0) begin
      errors++;
      $display("FAIL reset_mid_outputs: status %h cmd %b data %h want all 0", status, eng_cmd, eng_data_in);
    end
    eng_done = 1'b1;
    tick();
    eng_done = 1'b0;
    tick();
    rst = 1'b1;
    model_reset();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (rsp_valid !== '0 || status !== 8'h00) begin
        errors++;
        $display("FAIL reset_mid_quiet: rsp_valid %b status %h want 0 00", rsp_valid, status);
      end
    end
    run_cmd(2'b11, 4'b1011, 16'h5A5A, 2'b00, 2, 8'h77, 1'b1, won);
    checks++;
    if (won !== 0) begin
      errors++;
      $display("FAIL reset_mid_first: got %0d want 0", won);
    end
    check_status("reset_mid");
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single();
    test_lock();
    test_timeout();
    test_read();
    test_done_ignored();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
